// File: rtl/dmem_if.sv
`default_nettype none
// ============================================================================
// Module   : dmem_if
// Purpose  : Data request/response bundle from the memory stage to the data
//            memory responder.
// Revision : 1.0 - initial release
// ============================================================================
interface dmem_if;
  logic        req_read;
  logic        req_write;
  logic [29:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_is_write;
  logic        rsp_err;

  modport master (
    output req_read, req_write, req_addr, req_wdata, req_be,
    input  req_ready, rsp_valid, rsp_rdata, rsp_is_write, rsp_err
  );

  modport slave (
    input  req_read, req_write, req_addr, req_wdata, req_be,
    output req_ready, rsp_valid, rsp_rdata, rsp_is_write, rsp_err
  );
endinterface
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Purpose  : Word-addressed data memory with byte-lane writes, configurable
//            wait states and a one-cycle response strobe.
// Options  : DMEM_RANGE_CHECK_EN - flag and suppress out-of-range accesses.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_responder #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 1
) (
  input  wire logic clk,
  input  wire logic rst,
  dmem_if.slave     bus
);

  localparam int         c_IDX_W     = $clog2(DEPTH);
  localparam logic [3:0] c_WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  localparam logic [1:0] c_IDLE   = 2'd0;
  localparam logic [1:0] c_WAIT   = 2'd1;
  localparam logic [1:0] c_ACCESS = 2'd2;
  localparam logic [1:0] c_RESP   = 2'd3;

  logic [1:0]         r_state;
  logic [3:0]         r_cnt;
  logic [c_IDX_W-1:0] r_addr;
  logic [31:0]        r_wdata;
  logic [3:0]         r_be;
  logic               r_is_write;
  logic               r_rsp_valid;
  logic [31:0]        r_rsp_rdata;
  logic               r_rsp_is_write;
  logic               r_rsp_err;
  logic [31:0]        r_mem [DEPTH];

  logic               w_accept;
  logic               w_oor;
  logic               w_do_write;

`ifdef DMEM_RANGE_CHECK_EN
  logic r_oor;

  // Out-of-range status is resolved at acceptance so only index bits are kept.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_oor <= 1'b0;
    end else if (w_accept) begin
      r_oor <= |(bus.req_addr >> c_IDX_W);
    end
  end

  assign w_oor = r_oor;
`else
  assign w_oor = 1'b0;
`endif

  assign w_accept   = (bus.req_read | bus.req_write) && (r_state == c_IDLE);
  assign w_do_write = (r_state == c_ACCESS) && r_is_write && !w_oor;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= c_IDLE;
      r_cnt          <= 4'd0;
      r_addr         <= '0;
      r_wdata        <= 32'd0;
      r_be           <= 4'd0;
      r_is_write     <= 1'b0;
      r_rsp_valid    <= 1'b0;
      r_rsp_rdata    <= 32'd0;
      r_rsp_is_write <= 1'b0;
      r_rsp_err      <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_accept) begin
            r_addr     <= bus.req_addr[c_IDX_W-1:0];
            r_wdata    <= bus.req_wdata;
            r_be       <= bus.req_be;
            r_is_write <= bus.req_write;
            if (WAIT_STATES > 0) begin
              r_cnt   <= c_WAIT_LOAD;
              r_state <= c_WAIT;
            end else begin
              r_state <= c_ACCESS;
            end
          end
        end
        c_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state <= c_ACCESS;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        c_ACCESS: begin
          // Writes and suppressed accesses report zero read data.
          r_rsp_valid    <= 1'b1;
          r_rsp_is_write <= r_is_write;
          r_rsp_err      <= w_oor;
          r_rsp_rdata    <= (!r_is_write && !w_oor) ? r_mem[r_addr] : 32'd0;
          r_state        <= c_RESP;
        end
        c_RESP: begin
          r_rsp_valid <= 1'b0;
          r_state     <= c_IDLE;
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  // Array has no reset; its contents survive rst.
  always_ff @(posedge clk) begin
    if (w_do_write) begin
      for (int i = 0; i < 4; i++) begin
        if (r_be[i]) begin
          r_mem[r_addr][8*i +: 8] <= r_wdata[8*i +: 8];
        end
      end
    end
  end

  assign bus.req_ready    = (r_state == c_IDLE);
  assign bus.rsp_valid    = r_rsp_valid;
  assign bus.rsp_rdata    = r_rsp_rdata;
  assign bus.rsp_is_write = r_rsp_is_write;
  assign bus.rsp_err      = r_rsp_err;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_responder
// Purpose  : Directed self-checking bench; three responders (WAIT_STATES 1, 0
//            and 3) receive identical requests and are checked side by side.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_read;
  logic        req_write;
  logic [29:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;

  int checks = 0;
  int errors = 0;

`ifdef DMEM_RANGE_CHECK_EN
  localparam bit c_RC = 1'b1;
`else
  localparam bit c_RC = 1'b0;
`endif

  dmem_if bus_a ();
  dmem_if bus_b ();
  dmem_if bus_c ();

  assign bus_a.req_read = req_read;  assign bus_b.req_read = req_read;  assign bus_c.req_read = req_read;
  assign bus_a.req_write = req_write; assign bus_b.req_write = req_write; assign bus_c.req_write = req_write;
  assign bus_a.req_addr = req_addr;  assign bus_b.req_addr = req_addr;  assign bus_c.req_addr = req_addr;
  assign bus_a.req_wdata = req_wdata; assign bus_b.req_wdata = req_wdata; assign bus_c.req_wdata = req_wdata;
  assign bus_a.req_be = req_be;      assign bus_b.req_be = req_be;      assign bus_c.req_be = req_be;

  dmem_responder #(.DEPTH(1024), .WAIT_STATES(1)) u_dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
  dmem_responder #(.DEPTH(1024), .WAIT_STATES(0)) u_dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));
  dmem_responder #(.DEPTH(1024), .WAIT_STATES(3)) u_dut_c (.clk(clk), .rst(rst), .bus(bus_c.slave));

  logic [2:0]        mon_valid, mon_iw, mon_err, mon_rdy;
  logic [2:0][31:0]  mon_rdata;
  assign mon_valid = {bus_c.rsp_valid, bus_b.rsp_valid, bus_a.rsp_valid};
  assign mon_iw    = {bus_c.rsp_is_write, bus_b.rsp_is_write, bus_a.rsp_is_write};
  assign mon_err   = {bus_c.rsp_err, bus_b.rsp_err, bus_a.rsp_err};
  assign mon_rdy   = {bus_c.req_ready, bus_b.req_ready, bus_a.req_ready};
  assign mon_rdata = {bus_c.rsp_rdata, bus_b.rsp_rdata, bus_a.rsp_rdata};

  always #5 clk = ~clk;

  function automatic int ws(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 0 : 3);
  endfunction

  // Observations from the most recent do_op, per DUT.
  int          obs_nval [3];
  int          obs_lat  [3];
  logic [31:0] obs_rdata[3];
  logic [31:0] obs_hold [3];
  logic        obs_iw   [3];
  logic        obs_err  [3];
  logic [7:0]  obs_rdy  [3];

  // Issues one request and records seven cycles of response behaviour.
  // Cycle 0 is the acceptance cycle; bit c of obs_rdy is req_ready in cycle c.
  task automatic do_op(input logic rd, input logic wr, input logic [29:0] a,
                       input logic [31:0] wd, input logic [3:0] be);
    @(negedge clk);
    req_read = rd; req_write = wr; req_addr = a; req_wdata = wd; req_be = be;
    for (int k = 0; k < 3; k++) begin
      obs_nval[k] = 0; obs_lat[k] = -1; obs_rdata[k] = 'x; obs_hold[k] = 'x;
      obs_iw[k] = 1'bx; obs_err[k] = 1'bx; obs_rdy[k] = 8'd0;
      obs_rdy[k][0] = mon_rdy[k];
    end
    @(posedge clk);
    #1;
    req_read = 1'b0; req_write = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        obs_rdy[k][c] = mon_rdy[k];
        if (mon_valid[k]) begin
          obs_nval[k]++; obs_lat[k] = c;
          obs_rdata[k] = mon_rdata[k]; obs_iw[k] = mon_iw[k]; obs_err[k] = mon_err[k];
        end
        if (c == 7) obs_hold[k] = mon_rdata[k];
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; req_read = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      checks++; if ({mon_valid[k], mon_iw[k], mon_err[k], mon_rdy[k]} !== 4'b0001) begin
        errors++; $display("FAIL reset_flags dut%0d: got v/iw/err/rdy %b%b%b%b expected 0001", k, mon_valid[k], mon_iw[k], mon_err[k], mon_rdy[k]); end
      checks++; if (mon_rdata[k] !== 32'd0) begin
        errors++; $display("FAIL reset_rdata dut%0d: got %h expected 00000000", k, mon_rdata[k]); end
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_word();
    do_op(1'b0, 1'b1, 30'h10, 32'hDEADBEEF, 4'b1111);
    for (int k = 0; k < 3; k++) begin
      checks++; if (obs_iw[k] !== 1'b1 || obs_rdata[k] !== 32'd0 || obs_err[k] !== 1'b0) begin
        errors++; $display("FAIL word_write_rsp dut%0d: got iw=%b rdata=%h err=%b expected iw=1 rdata=00000000 err=0", k, obs_iw[k], obs_rdata[k], obs_err[k]); end
    end
    checks++; if (obs_lat[0] !== 3) begin
      errors++; $display("FAIL word_write_latency dut0: got %0d expected 3", obs_lat[0]); end
    do_op(1'b1, 1'b0, 30'h10, 32'h0, 4'b0000);
    for (int k = 0; k < 3; k++) begin
      checks++; if (obs_iw[k] !== 1'b0 || obs_rdata[k] !== 32'hDEADBEEF) begin
        errors++; $display("FAIL word_read dut%0d: got iw=%b rdata=%h expected iw=0 rdata=deadbeef", k, obs_iw[k], obs_rdata[k]); end
      checks++; if (obs_hold[k] !== 32'hDEADBEEF) begin
        errors++; $display("FAIL word_read_hold dut%0d: got %h expected deadbeef", k, obs_hold[k]); end
    end
  endtask

  task automatic test_byte_lanes();
    do_op(1'b0, 1'b1, 30'h10, 32'h11223344, 4'b0101);
    do_op(1'b1, 1'b0, 30'h10, 32'h0, 4'b0000);
    for (int k = 0; k < 3; k++) begin
      checks++; if (obs_rdata[k] !== 32'hDE22BE44) begin
        errors++; $display("FAIL lanes_0101 dut%0d: got %h expected de22be44", k, obs_rdata[k]); end
    end
    do_op(1'b0, 1'b1, 30'h10, 32'hFFFFFFFF, 4'b0000);
    for (int k = 0; k < 3; k++) begin
      checks++; if (obs_nval[k] !== 1 || obs_iw[k] !== 1'b1 || obs_rdata[k] !== 32'd0) begin
        errors++; $display("FAIL lanes_0000_rsp dut%0d: got nval=%0d iw=%b rdata=%h expected 1 1 00000000", k, obs_nval[k], obs_iw[k], obs_rdata[k]); end
    end
    do_op(1'b1, 1'b0, 30'h10, 32'h0, 4'b1111);
    for (int k = 0; k < 3; k++) begin
      checks++; if (obs_rdata[k] !== 32'hDE22BE44) begin
        errors++; $display("FAIL lanes_0000_mem dut%0d: got %h expected de22be44", k, obs_rdata[k]); end
    end
  endtask

  task automatic test_wait_states();
    logic [7:0] exp_rdy;
    do_op(1'b1, 1'b0, 30'h10, 32'h0, 4'b1111);
    for (int k = 0; k < 3; k++) begin
      exp_rdy = (k == 0) ? 8'hF1 : ((k == 1) ? 8'hF9 : 8'hC1);
      checks++; if (obs_nval[k] !== 1) begin
        errors++; $display("FAIL ws_pulse_count dut%0d: got %0d expected 1", k, obs_nval[k]); end
      checks++; if (obs_lat[k] !== ws(k) + 2) begin
        errors++; $display("FAIL ws_latency dut%0d: got %0d expected %0d", k, obs_lat[k], ws(k) + 2); end
      checks++; if (obs_rdy[k] !== exp_rdy) begin
        errors++; $display("FAIL ws_ready_trace dut%0d: got %b expected %b", k, obs_rdy[k], exp_rdy); end
    end
  endtask

  task automatic test_reset_mid_op();
    int nval [3];
    do_op(1'b0, 1'b1, 30'h20, 32'h12345678, 4'b1111);
    @(negedge clk);
    req_write = 1'b1; req_addr = 30'h20; req_wdata = 32'hCAFEF00D; req_be = 4'b1111;
    @(posedge clk);
    #1;
    req_write = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++; if ({mon_valid[k], mon_iw[k], mon_err[k], mon_rdy[k]} !== 4'b0001 || mon_rdata[k] !== 32'd0) begin
        errors++; $display("FAIL midop_reset_outputs dut%0d: got v/iw/err/rdy %b%b%b%b rdata=%h expected 0001 00000000", k, mon_valid[k], mon_iw[k], mon_err[k], mon_rdy[k], mon_rdata[k]); end
      nval[k] = 0;
    end
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) if (mon_valid[k]) nval[k]++;
    end
    for (int k = 0; k < 3; k++) begin
      checks++; if (nval[k] !== 0) begin
        errors++; $display("FAIL midop_no_response dut%0d: got %0d pulses expected 0", k, nval[k]); end
    end
    do_op(1'b1, 1'b0, 30'h20, 32'h0, 4'b1111);
    for (int k = 0; k < 3; k++) begin
      checks++; if (obs_rdata[k] !== 32'h12345678) begin
        errors++; $display("FAIL midop_mem_kept dut%0d: got %h expected 12345678", k, obs_rdata[k]); end
    end
  endtask

  task automatic test_simultaneous();
    do_op(1'b1, 1'b1, 30'h30, 32'h0000ABCD, 4'b1111);
    for (int k = 0; k < 3; k++) begin
      checks++; if (obs_iw[k] !== 1'b1 || obs_rdata[k] !== 32'd0) begin
        errors++; $display("FAIL simul_rsp dut%0d: got iw=%b rdata=%h expected iw=1 rdata=00000000", k, obs_iw[k], obs_rdata[k]); end
    end
    do_op(1'b1, 1'b0, 30'h30, 32'h0, 4'b1111);
    for (int k = 0; k < 3; k++) begin
      checks++; if (obs_rdata[k] !== 32'h0000ABCD) begin
        errors++; $display("FAIL simul_mem dut%0d: got %h expected 0000abcd", k, obs_rdata[k]); end
    end
  endtask

  task automatic test_range();
    logic [31:0] exp_alias;
    exp_alias = c_RC ? 32'hDE22BE44 : 32'h55555555;
    do_op(1'b0, 1'b1, 30'h410, 32'h55555555, 4'b1111);
    for (int k = 0; k < 3; k++) begin
      checks++; if (obs_err[k] !== c_RC || obs_iw[k] !== 1'b1 || obs_lat[k] !== ws(k) + 2) begin
        errors++; $display("FAIL range_write_rsp dut%0d: got err=%b iw=%b lat=%0d expected %b 1 %0d", k, obs_err[k], obs_iw[k], obs_lat[k], c_RC, ws(k) + 2); end
    end
    do_op(1'b1, 1'b0, 30'h010, 32'h0, 4'b1111);
    for (int k = 0; k < 3; k++) begin
      checks++; if (obs_rdata[k] !== exp_alias || obs_err[k] !== 1'b0) begin
        errors++; $display("FAIL range_inrange_read dut%0d: got rdata=%h err=%b expected %h 0", k, obs_rdata[k], obs_err[k], exp_alias); end
    end
    do_op(1'b1, 1'b0, 30'h410, 32'h0, 4'b1111);
    for (int k = 0; k < 3; k++) begin
      checks++; if (obs_rdata[k] !== (c_RC ? 32'd0 : 32'h55555555) || obs_err[k] !== c_RC) begin
        errors++; $display("FAIL range_oor_read dut%0d: got rdata=%h err=%b expected %h %b", k, obs_rdata[k], obs_err[k], c_RC ? 32'd0 : 32'h55555555, c_RC); end
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte_lanes();
    test_wait_states();
    test_reset_mid_op();
    test_simultaneous();
    test_range();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
